pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 84 ++++++++
 tb/tb_pipelined_adder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-pipelined adder/subtractor with valid/ready handshake.
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset, clears all stage state
//   in_valid  - operand set present; accepted when in_ready is also 1
//   in_ready  - low only while the output is stalled
//   a, b      - operands; cin carry/borrow-in; sub selects subtract
//   out_valid - result present; consumed when out_ready is 1
//   sum, cout - result and carry-out (subtract: cout=1 means no borrow)
//   overflow  - two's-complement signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic stall;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q, a_d, b_d, s_d, s_n;
  logic [STAGES-1:0] c_q, v_q, c_d, v_d, c_n;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  // Stage inputs: stage 0 takes the (possibly inverted) operands, later
  // stages take the previous stage registers.
  always_comb begin
    a_d = '0;
    b_d = '0;
    s_d = '0;
    c_d = '0;
    v_d = '0;
    s_n = '0;
    c_n = '0;
    a_d[0] = a;
    b_d[0] = b ^ {WIDTH{sub}};
    c_d[0] = cin ^ sub;
    v_d[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      a_d[s] = a_q[s-1];
      b_d[s] = b_q[s-1];
      s_d[s] = s_q[s-1];
      c_d[s] = c_q[s-1];
      v_d[s] = v_q[s-1];
    end
    // Each stage resolves only its own slice; lower slices pass through.
    for (int s = 0; s < STAGES; s++) begin
      s_n[s] = s_d[s];
      {c_n[s], s_n[s][s*SW +: SW]} = {1'b0, a_d[s][s*SW +: SW]}
                                   + {1'b0, b_d[s][s*SW +: SW]}
                                   + {{SW{1'b0}}, c_d[s]};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      v_q <= '0;
    end else if (!stall) begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_n;
      c_q <= c_n;
      v_q <= v_d;
    end
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];
  // The last stage still holds a and b_eff, so overflow is derived from
  // their sign bits and the finished sum.
  assign overflow  = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) & (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4).
//   Driver pushes the expected {cout,sum,overflow} on acceptance; a negedge
//   monitor pops and compares whenever a result is consumed.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic in_ready, out_valid, cout, overflow;
  logic [W-1:0] a = '0, b = '0, sum;
  int tests = 0, fails = 0, cyc = 0, stall_cnt = 0;
  bit exact = 0, prev_stall = 0, done = 0;
  logic [W+1:0] prev_data;
  typedef struct {logic [W+1:0] r; int c; bit ex;} exp_t;
  exp_t q[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W+1:0] model(logic [W-1:0] av, logic [W-1:0] bv, logic ci, logic sb);
    logic [W-1:0] be;
    logic [W:0] t;
    be = bv ^ {W{sb}};
    t = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ci ^ sb};
    return {t[W], t[W-1:0], (av[W-1] == be[W-1]) && (t[W-1] != av[W-1])};
  endfunction

  task automatic send(logic [W-1:0] av, logic [W-1:0] bv, logic ci, logic sb, logic [W+1:0] r);
    int n = 0;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    q.push_back('{r, cyc, exact});
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {cout, sum, overflow}, prev_data);
      end
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got sum %h with empty scoreboard, required none", sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", {cout, sum, overflow}, e.r);
          if (e.ex) check("latency", cyc - e.c, S);
        end
      end
      if (!in_ready) stall_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data = {cout, sum, overflow};
    end else prev_stall = 0;

  initial begin
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", {cout, sum, overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1 check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    exact = 1;
    send(32'h7FFFFFFF, 32'h00000001, 0, 0, {1'b0, 32'h80000000, 1'b1});
    send(32'h00000010, 32'h00000020, 0, 1, {1'b0, 32'hFFFFFFF0, 1'b0});
    send(32'h80000000, 32'h00000001, 0, 1, {1'b1, 32'h7FFFFFFF, 1'b1});
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, {1'b1, 32'hFFFFFFFF, 1'b0});
    send(32'h00000005, 32'h00000003, 1, 1, {1'b1, 32'h00000001, 1'b0});
    send(32'h0000FFFF, 32'h00000001, 0, 0, {1'b0, 32'h00010000, 1'b0});
    send(32'h00FFFFFF, 32'h00000001, 0, 0, {1'b0, 32'h01000000, 1'b0});
    repeat (6) @(posedge clk); #1;
    exact = 0;
    stall_cnt = 0;
    fork
      for (int i = 0; i < 8; i++) begin
        logic [W-1:0] av, bv;
        av = 32'h1234_5678 * (i + 1);
        bv = 32'h0F0F_F0F0 + i;
        send(av, bv, i[0], i[1], model(av, bv, i[0], i[1]));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    repeat (6) @(posedge clk); #1;
    check("stall_cycles", stall_cnt, 3);
    exact = 1;
    send(32'h00000001, 32'h00000002, 0, 0, {1'b0, 32'h00000003, 1'b0});
    send(32'h00000004, 32'h00000005, 0, 0, {1'b0, 32'h00000009, 1'b0});
    send(32'h00000006, 32'h00000007, 0, 0, {1'b0, 32'h0000000D, 1'b0});
    #1 rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_data", {cout, sum, overflow}, 0);
    check("arst_in_ready", in_ready, 1);
    q.delete();
    #1 rst_n = 1;
    repeat (8) @(posedge clk); #1;
    send(32'hFFFFFFFF, 32'h00000001, 0, 0, {1'b1, 32'h00000000, 1'b0});
    repeat (6) @(posedge clk); #1;
    exact = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [W-1:0] av, bv;
          logic ci, sb;
          if ($urandom_range(0, 3) == 0) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
          end
          av = $urandom; bv = $urandom; ci = 1'($urandom); sb = 1'($urandom);
          send(av, bv, ci, sb, model(av, bv, ci, sb));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    begin
      int n = 0;
      while (q.size() > 0 && n < 200) begin @(negedge clk); n++; end
      check("drain_left", q.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
